// File: rtl/bp_access_scheduler.sv
// ---------------------------------------------------------------------------
// bp_access_scheduler
//
// Shares the branch predictor's single access port between instruction-fetch
// prediction lookups and branch-outcome feedback updates.
//   * A prediction lookup has priority and is answered combinationally in the
//     same cycle.
//   * Feedback records are queued in a small FIFO and drained into the
//     predictor on cycles with no lookup.
//   * A guard forces a drain when the FIFO is full, or when the head entry has
//     waited STARVE_LIMIT cycles, so feedback is never starved.
//
// Ports
//   Sys_clk, Sys_rst        clock; synchronous active-high reset
//   Sys_rdy                 global enable (low = freeze, no grants)
//   IFSC_predict_en/_pc     prediction request from IF
//   SCIF_predict_grant      request served this cycle
//   SCIF_predict_result     predicted direction, valid with grant
//   IFSC_feedback_en/_pc,
//   IFSC_branch_result      resolved-branch record push from IF
//   SCIF_fb_full            FIFO full (registered count == depth)
//   SC_drop_cnt             saturating count of pushes rejected while full
//   SCPD_predict_en/_pc     lookup strobe and pc to the predictor
//   PDSC_predict_result     combinational lookup result from the predictor
//   SCPD_feedback_en/_pc,
//   SCPD_branch_result      update strobe, pc and outcome to the predictor
// ---------------------------------------------------------------------------
module bp_access_scheduler #(
  parameter int ADDR_WIDTH   = 32,
  parameter int FB_DEPTH_LOG = 2,
  parameter int STARVE_LIMIT = 8,
  parameter int DROP_CNT_W   = 8
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst,
  input  logic                  Sys_rdy,
  input  logic                  IFSC_predict_en,
  input  logic [ADDR_WIDTH-1:0] IFSC_pc,
  output logic                  SCIF_predict_grant,
  output logic                  SCIF_predict_result,
  input  logic                  IFSC_feedback_en,
  input  logic [ADDR_WIDTH-1:0] IFSC_feedback_pc,
  input  logic                  IFSC_branch_result,
  output logic                  SCIF_fb_full,
  output logic [DROP_CNT_W-1:0] SC_drop_cnt,
  output logic                  SCPD_predict_en,
  output logic [ADDR_WIDTH-1:0] SCPD_pc,
  input  logic                  PDSC_predict_result,
  output logic                  SCPD_feedback_en,
  output logic [ADDR_WIDTH-1:0] SCPD_feedback_pc,
  output logic                  SCPD_branch_result
);

  localparam int DEPTH = 1 << FB_DEPTH_LOG;
  localparam int PTR_W = FB_DEPTH_LOG;
  localparam int CNT_W = FB_DEPTH_LOG + 1;
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]      DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [AGE_W-1:0]      AGE_ONE   = AGE_W'(1);
  localparam logic [AGE_W-1:0]      AGE_MAX_C = AGE_W'(STARVE_LIMIT);
  localparam logic [DROP_CNT_W-1:0] DROP_ONE  = DROP_CNT_W'(1);

  // Which client owns the predictor port this cycle.
  typedef enum logic [1:0] {
    SEL_IDLE    = 2'd0,
    SEL_PREDICT = 2'd1,
    SEL_DRAIN   = 2'd2
  } sel_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic                  taken;
  } fb_rec_t;

  fb_rec_t                 fifo_mem_q [DEPTH];
  logic [PTR_W-1:0]        head_q, head_d;
  logic [PTR_W-1:0]        tail_q, tail_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [AGE_W-1:0]        age_q, age_d;
  logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  sel_e    sel;
  logic    active;
  logic    fifo_full;
  logic    fifo_nonempty;
  logic    force_fb;
  logic    pop;
  logic    push_req;
  logic    push;
  logic    drop;
  fb_rec_t head_rec;

  // -------------------------------------------------------------------------
  // Port selection. The guard is built from registered state only, so the
  // lookup path never depends on same-cycle pushes.
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default at the top;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    active        = Sys_rdy & ~Sys_rst;
    fifo_full     = (count_q == DEPTH_C);
    fifo_nonempty = (count_q != '0);
    force_fb      = fifo_full | (fifo_nonempty & (age_q >= AGE_MAX_C));
    head_rec      = fifo_mem_q[head_q];

    sel = SEL_IDLE;
    if (active && IFSC_predict_en && !force_fb) begin
      sel = SEL_PREDICT;
    end else if (active && fifo_nonempty) begin
      sel = SEL_DRAIN;
    end

    pop      = (sel == SEL_DRAIN);
    push_req = active & IFSC_feedback_en;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    push     = push_req & (~fifo_full | pop);
    drop     = push_req & ~push;
  end

  // -------------------------------------------------------------------------
  // Next-state for pointers, occupancy, head age and drop counter.
  // -------------------------------------------------------------------------
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    age_d      = age_q;
    drop_cnt_d = drop_cnt_q;

    if (pop) begin
      head_d = head_q + PTR_ONE;
    end
    if (push) begin
      tail_d = tail_q + PTR_ONE;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Age measures how long the current head has waited; a new head starts
    // from zero. Frozen cycles do not age it.
    if (active) begin
      if (pop || !fifo_nonempty) begin
        age_d = '0;
      end else if (age_q < AGE_MAX_C) begin
        age_d = age_q + AGE_ONE;
      end
    end

    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      age_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      age_q      <= age_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: the storage array has no reset; an entry is only read after it was
  // written, because count gates every drain. Leaving it unreset keeps it a
  // plain register file.
  always_ff @(posedge Sys_clk) begin
    if (push) begin
      fifo_mem_q[tail_q] <= '{pc: IFSC_feedback_pc, taken: IFSC_branch_result};
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. Data fields are zero whenever their strobe is low, and all
  // outputs are held at zero while reset is asserted.
  // -------------------------------------------------------------------------
  always_comb begin
    SCIF_predict_grant  = 1'b0;
    SCIF_predict_result = 1'b0;
    SCPD_predict_en     = 1'b0;
    SCPD_pc             = '0;
    SCPD_feedback_en    = 1'b0;
    SCPD_feedback_pc    = '0;
    SCPD_branch_result  = 1'b0;
    SCIF_fb_full        = fifo_full & ~Sys_rst;
    SC_drop_cnt         = Sys_rst ? '0 : drop_cnt_q;

    unique case (sel)
      SEL_PREDICT: begin
        SCIF_predict_grant  = 1'b1;
        SCIF_predict_result = PDSC_predict_result;
        SCPD_predict_en     = 1'b1;
        SCPD_pc             = IFSC_pc;
      end
      SEL_DRAIN: begin
        SCPD_feedback_en    = 1'b1;
        SCPD_feedback_pc    = head_rec.pc;
        SCPD_branch_result  = head_rec.taken;
      end
      default: ;
    endcase
  end

endmodule
